// File: rtl/i2s_stream_arbiter.sv
// i2s_stream_arbiter: two-input AXI-Stream burst arbiter feeding the I2S
// transmitter through a one-entry output register. Whole bursts are granted
// round-robin; a burst ends on tlast or after MAX_BURST beats.
// Optional feature: define I2S_ARB_SILENCE_FILL_EN to push zero (silence)
// frames into an empty output register while no requester is waiting.
module i2s_stream_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_BURST          = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                          s00_axis_tvalid,
    input  logic                          s00_axis_tlast,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                          s01_axis_tvalid,
    input  logic                          s01_axis_tlast,
    output logic                          s01_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    output logic [1:0]                    grant,
    output logic [CNT_WIDTH-1:0]          underrun_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                          state_q, state_d;
    logic                            owner_q, owner_d;   // 0 = s00, 1 = s01
    logic                            last_q, last_d;     // most recent winner
    logic [BW-1:0]                   beat_q, beat_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                            tlast_q, tlast_d;
    logic                            tvalid_q, tvalid_d;
    logic [CNT_WIDTH-1:0]            ucnt_q, ucnt_d;

    logic                            slot_free;
    logic                            sel_valid;
    logic                            sel_last;
    logic [C_AXIS_TDATA_WIDTH-1:0]   sel_data;
    logic                            accept;
    logic                            fill;
    logic                            winner;

    // Output register can take a beat when empty or draining this cycle.
    assign slot_free       = !tvalid_q || m00_axis_tready;
    assign s00_axis_tready = (state_q == ST_GRANT) && !owner_q && slot_free;
    assign s01_axis_tready = (state_q == ST_GRANT) &&  owner_q && slot_free;
    assign grant           = (state_q == ST_GRANT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign underrun_cnt    = ucnt_q;

    // Next-state logic: arbitration, burst tracking, output register, underrun counter.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        beat_d   = beat_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        ucnt_d   = ucnt_q;
        accept   = 1'b0;
        fill     = 1'b0;
        winner   = 1'b0;

        sel_valid = owner_q ? s01_axis_tvalid : s00_axis_tvalid;
        sel_last  = owner_q ? s01_axis_tlast  : s00_axis_tlast;
        sel_data  = owner_q ? s01_axis_tdata  : s00_axis_tdata;

        case (state_q)
            ST_IDLE: begin
                if (s00_axis_tvalid || s01_axis_tvalid) begin
                    // Contention goes to whoever did not win last time.
                    winner  = (s00_axis_tvalid && s01_axis_tvalid) ? !last_q : s01_axis_tvalid;
                    state_d = ST_GRANT;
                    owner_d = winner;
                    last_d  = winner;
                end
`ifdef I2S_ARB_SILENCE_FILL_EN
                else if (!tvalid_q && m00_axis_tready) begin
                    fill = 1'b1;
                end
`endif
            end
            ST_GRANT: begin
                if (sel_valid && slot_free) begin
                    accept = 1'b1;
                    if (sel_last || beat_q == BW'(MAX_BURST - 1)) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load wins over a drain, so simultaneous drain+load keeps tvalid high.
        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = sel_data;
            tlast_d  = sel_last;
        end else if (fill) begin
            tvalid_d = 1'b1;
            tdata_d  = '0;
            tlast_d  = 1'b1;
        end else if (tvalid_q && m00_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (m00_axis_tready && !tvalid_q && ucnt_q != '1) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    // State and datapath registers; reset drops any buffered beat.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            beat_q   <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            ucnt_q   <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_stream_arbiter.sv
// Testbench for i2s_stream_arbiter: a directed vector table, hand-written
// corner sequences and randomized traffic checked against a transaction-level
// model built from the arbitration rules. Honours I2S_ARB_SILENCE_FILL_EN.
module tb_i2s_stream_arbiter;

    localparam int W  = 32;
    localparam int MB = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s0d, s1d, md;
    logic          s0v, s1v, s0l, s1l, s0r, s1r;
    logic          mv, ml, mr;
    logic [1:0]    grant;
    logic [CW-1:0] ur;

    always #5 clk = ~clk;

    i2s_stream_arbiter #(.C_AXIS_TDATA_WIDTH(W), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s00_axis_tdata  (s0d),
        .s00_axis_tvalid (s0v),
        .s00_axis_tlast  (s0l),
        .s00_axis_tready (s0r),
        .s01_axis_tdata  (s1d),
        .s01_axis_tvalid (s1v),
        .s01_axis_tlast  (s1l),
        .s01_axis_tready (s1r),
        .m00_axis_tdata  (md),
        .m00_axis_tvalid (mv),
        .m00_axis_tlast  (ml),
        .m00_axis_tready (mr),
        .grant           (grant),
        .underrun_cnt    (ur)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_owner;   // -1 idle, else requester index
    int          m_last;
    int          m_beats;
    logic        m_v;
    logic [W-1:0] m_d;
    logic        m_l;
    int          m_ur;
    logic        acc [2];

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_beats = 0;
        m_v = 1'b0; m_d = '0; m_l = 1'b0; m_ur = 0;
        acc[0] = 1'b0; acc[1] = 1'b0;
    endtask

    function automatic logic [1:0] m_grant();
        return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic m_rdy(input int s);
        return (m_owner == s) && (!m_v || mr);
    endfunction

    task automatic model_step();
        logic drain, v, l, fill, was_idle;
        logic [W-1:0] d;
        int w;
        fill = 1'b0; d = '0; l = 1'b0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        drain = m_v && mr;
        was_idle = (m_owner < 0);
        if (was_idle) begin
            if (s0v || s1v) begin
                if (s0v && s1v) w = 1 - m_last;
                else            w = s0v ? 0 : 1;
                m_owner = w;
                m_last  = w;
            end
        end else begin
            v = (m_owner == 0) ? s0v : s1v;
            l = (m_owner == 0) ? s0l : s1l;
            d = (m_owner == 0) ? s0d : s1d;
            if (v && (!m_v || mr)) begin
                acc[m_owner] = 1'b1;
                m_beats++;
                if (l || m_beats == MB) begin
                    m_owner = -1;
                    m_beats = 0;
                end
            end
        end
`ifdef I2S_ARB_SILENCE_FILL_EN
        if (was_idle && !s0v && !s1v && !m_v && mr) fill = 1'b1;
`endif
        if (mr && !m_v && m_ur < (1 << CW) - 1) m_ur++;
        if (acc[0] || acc[1]) begin
            m_v = 1'b1; m_d = d; m_l = l;
        end else if (fill) begin
            m_v = 1'b1; m_d = '0; m_l = 1'b1;
        end else if (drain) begin
            m_v = 1'b0;
        end
    endtask

    // ---------------- requester drivers and bookkeeping ----------------
    logic         hv [2];
    logic [W-1:0] cd [2];
    logic         cl [2];
    int           rem [2];
    int           seq [2];
    int           blen [2];   // >0 fixed, 0 random 1..20, -1 never tlast
    logic         active [2];
    logic [1:0]   ep_g [$];
    int           ep_n [$];
    logic [1:0]   prev_g, first_g;
    int           ep_cnt, n_in, n_out;

    task automatic src_reset();
        for (int s = 0; s < 2; s++) begin
            hv[s] = 1'b0; cd[s] = '0; cl[s] = 1'b0;
            rem[s] = 0; seq[s] = 0; blen[s] = 0; active[s] = 1'b0;
        end
        ep_g.delete(); ep_n.delete();
        prev_g = 2'b00; first_g = 2'b00; ep_cnt = 0; n_in = 0; n_out = 0;
    endtask

    task automatic drive(input int pct, input int rmode, input int cyc);
        for (int s = 0; s < 2; s++) begin
            if (active[s] && !hv[s] && int'($urandom_range(99)) < pct) begin
                if (rem[s] == 0)
                    rem[s] = (blen[s] > 0) ? blen[s] : (blen[s] == 0) ? int'($urandom_range(20, 1)) : 100000;
                hv[s] = 1'b1;
                cd[s] = {8'hA0 + 8'(s), 8'h00, 16'(seq[s])};
                cl[s] = (rem[s] == 1);
            end
        end
        s0v = hv[0]; s0d = cd[0]; s0l = cl[0] & hv[0];
        s1v = hv[1]; s1d = cd[1]; s1l = cl[1] & hv[1];
        mr  = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(1));
    endtask

    task automatic check_outputs();
        check("grant", grant, m_grant());
        check("s00_tready", s0r, m_rdy(0));
        check("s01_tready", s1r, m_rdy(1));
        check("m_tvalid", mv, m_v);
        if (m_v) begin
            check("m_tdata", md, m_d);
            check("m_tlast", ml, m_l);
        end
        check("underrun_cnt", ur, m_ur);
    endtask

    // One clock: inputs already applied at the falling edge.
    task automatic cycle();
        logic [1:0] g;
        logic hs;
        #1;
        check_outputs();
        g  = grant;
        hs = (g == 2'b01 && s0v && s0r) || (g == 2'b10 && s1v && s1r);
        if (g != prev_g) begin
            if (prev_g != 2'b00) begin
                ep_g.push_back(prev_g);
                ep_n.push_back(ep_cnt);
            end
            ep_cnt = 0;
        end
        if (hs) ep_cnt++;
        if (first_g == 2'b00) first_g = g;
        prev_g = g;
        if (mv && mr) n_out++;
        model_step();
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
                hv[s] = 1'b0; rem[s]--; seq[s]++; n_in++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input int pct, input int rmode);
        for (int c = 0; c < n; c++) begin
            drive(pct, rmode, c);
            cycle();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s0v = 1'b0; s1v = 1'b0; s0l = 1'b0; s1l = 1'b0;
        s0d = '0; s1d = '0; mr = 1'b0;
        model_reset();
        src_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_tvalid", mv, 1'b0);
        check("rst_tdata", md, '0);
        check("rst_tlast", ml, 1'b0);
        check("rst_s00_tready", s0r, 1'b0);
        check("rst_s01_tready", s1r, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_underrun", ur, '0);
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         s0v;
        logic [31:0]  s0d;
        logic         s0l;
        logic         mr;
        logic [1:0]   g;
        logic         r0;
        logic         r1;
        logic         mv;
        logic [31:0]  md;
        logic         ml;
        int           ur;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 32'hAA558001, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 0};
        tbl[1] = '{1'b1, 32'hAA558001, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1};
        tbl[2] = '{1'b1, 32'hA5A58001, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'hAA558001, 1'b0, 2};
        tbl[3] = '{1'b1, 32'h00000001, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'hA5A58001, 1'b0, 2};
        tbl[4] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b1, 2};
        tbl[5] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b1, 2};

        apply_reset();
        for (int i = 0; i < 6; i++) begin
            s0v = tbl[i].s0v; s0d = tbl[i].s0d; s0l = tbl[i].s0l; mr = tbl[i].mr;
            s1v = 1'b0; s1d = '0; s1l = 1'b0;
            #1;
            check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            check($sformatf("tbl%0d_s00_tready", i), s0r, tbl[i].r0);
            check($sformatf("tbl%0d_s01_tready", i), s1r, tbl[i].r1);
            check($sformatf("tbl%0d_m_tvalid", i), mv, tbl[i].mv);
            check($sformatf("tbl%0d_m_tdata", i), md, tbl[i].md);
            check($sformatf("tbl%0d_m_tlast", i), ml, tbl[i].ml);
            check($sformatf("tbl%0d_underrun", i), ur, 64'(tbl[i].ur));
            @(negedge clk);
        end

        // Both requesters always valid with 2-beat bursts: grants alternate.
        apply_reset();
        active[0] = 1'b1; active[1] = 1'b1; blen[0] = 2; blen[1] = 2;
        run(20, 100, 0);
        check("alt_episodes", ep_g.size() >= 4, 1'b1);
        if (ep_g.size() >= 4) begin
            check("alt_g0", ep_g[0], 2'b01);
            check("alt_g1", ep_g[1], 2'b10);
            check("alt_g2", ep_g[2], 2'b01);
            check("alt_g3", ep_g[3], 2'b10);
            check("alt_len0", 64'(ep_n[0]), 2);
        end

        // s01 never sends tlast: grant released after MAX_BURST beats, s00 next.
        apply_reset();
        active[1] = 1'b1; blen[1] = -1;
        run(3, 100, 0);
        active[0] = 1'b1; blen[0] = 2;
        run(30, 100, 0);
        check("mb_episodes", ep_g.size() >= 2, 1'b1);
        if (ep_g.size() >= 2) begin
            check("mb_first_owner", ep_g[0], 2'b10);
            check("mb_first_len", 64'(ep_n[0]), MB);
            check("mb_next_owner", ep_g[1], 2'b01);
        end

        // Transmitter ready toggling every cycle: no beat lost or duplicated.
        apply_reset();
        active[0] = 1'b1; active[1] = 1'b1;
        run(80, 100, 1);
        check("toggle_conserve", 64'(n_in - n_out), 64'(m_v));
        check("toggle_progress", n_out > 10, 1'b1);

        // No requesters for 10 cycles with the transmitter ready.
        apply_reset();
        run(10, 0, 0);
        #1;
`ifndef I2S_ARB_SILENCE_FILL_EN
        check("idle_underrun", ur, 10);
        check("idle_tvalid", mv, 1'b0);
`else
        check("fill_drained", n_out >= 4, 1'b1);
`endif
        @(negedge clk);

        // Reset asserted mid-burst while the output register is stalled.
        apply_reset();
        active[0] = 1'b1; blen[0] = 10;
        run(4, 100, 0);
        for (int c = 0; c < 2; c++) begin
            drive(100, 0, c);
            mr = 1'b0;
            cycle();
        end
        #1;
        check("stall_tvalid", mv, 1'b1);
        check("stall_s00_tready", s0r, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_tvalid", mv, 1'b0);
        check("arst_s00_tready", s0r, 1'b0);
        check("arst_grant", grant, 2'b00);
        @(negedge clk);
        apply_reset();
        active[0] = 1'b1; active[1] = 1'b1; blen[0] = 2; blen[1] = 2;
        run(6, 100, 0);
        check("post_rst_first_grant", first_g, 2'b01);

        // Randomized traffic with random back-pressure.
        apply_reset();
        active[0] = 1'b1; active[1] = 1'b1;
        run(1500, 60, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_stream_arbiter.md
# i2s_stream_arbiter

Two-input AXI-Stream arbiter that shares the single audio transmit stream of the I2S transmitter between the two CPUs. Each requester sends bursts of 32-bit stereo frames ({L[31:16], R[15:0]}). The block grants whole bursts round-robin and drives the transmitter's `s00_axis` input through a one-entry output register. It sits between the two CPU DMA/stream masters and the I2S transmitter, in the `s00_axis_aclk` domain.

## Interface
- `C_AXIS_TDATA_WIDTH`, 32, data width of all streams
- `MAX_BURST`, 16, maximum beats per grant (1..255)
- `CNT_WIDTH`, 16, width of the underrun counter

- `axis_aclk` in 1: single clock; all logic on its rising edge
- `axis_areset` in 1: asynchronous, active-high reset
- `s00_axis_tdata` in `C_AXIS_TDATA_WIDTH`: requester 0 frame
- `s00_axis_tvalid` in 1: requester 0 valid
- `s00_axis_tlast` in 1: requester 0 end of burst
- `s00_axis_tready` out 1: requester 0 accept
- `s01_axis_tdata`, `s01_axis_tvalid`, `s01_axis_tlast` in: requester 1, same meaning as `s00`
- `s01_axis_tready` out 1: requester 1 accept
- `m00_axis_tdata` out `C_AXIS_TDATA_WIDTH`: frame to the I2S transmitter
- `m00_axis_tvalid` out 1: output valid
- `m00_axis_tlast` out 1: copy of the accepted beat's tlast
- `m00_axis_tready` in 1: transmitter accept
- `grant` out 2: one-hot current owner; 00 when idle
- `underrun_cnt` out `CNT_WIDTH`: saturating count of starved cycles

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner `g` ∈ {0,1}.
- Priority register `last`: the most recently granted requester. Reset value 1, so `s00` wins first.
- IDLE → GRANT when any `sNN_axis_tvalid`=1.
  - If both are valid, the requester ≠ `last` wins.
  - If one is valid, that requester wins.
  - Set `g` and `last` to the winner.
- In GRANT:
  - `sg_axis_tready` = !`m00_axis_tvalid` || `m00_axis_tready`.
  - The non-owner's tready = 0.
  - Accept = `sg_tvalid` && `sg_tready`.
  - On accept, load the output register: tdata, tlast, `m00_axis_tvalid`=1.
  - Increment the beat counter on each accept.
- GRANT → IDLE on an accept where tlast=1, or where the beat counter reaches `MAX_BURST`. The counter clears on that transition.
- Output register:
  - `m00_axis_tvalid` clears on (`m00_axis_tvalid` && `m00_axis_tready`) with no simultaneous load.
  - A simultaneous drain and load keeps tvalid=1 with the new data.
  - Data is held stable while tvalid=1 and tready=0.
- A requester dropping tvalid mid-burst does not release the grant. The owner holds the grant until tlast or `MAX_BURST`.
- `underrun_cnt` increments each cycle with `m00_axis_tready`=1 and `m00_axis_tvalid`=0, and saturates at all ones.
- Reset mid-operation:
  - State → IDLE, `last` → 1, beat counter → 0.
  - The output register is dropped (tvalid=0).
  - `underrun_cnt` → 0.

## Timing
- Reset values:
  - `m00_axis_tvalid`=0, `m00_axis_tdata`=0, `m00_axis_tlast`=0.
  - `s00_axis_tready`=0, `s01_axis_tready`=0.
  - `grant`=00, `underrun_cnt`=0.
- Arbitration takes 1 cycle: the IDLE cycle in which tvalid is sampled. `grant` and tready are asserted from the next cycle.
- Latency from input accept to `m00_axis_tvalid` is 1 cycle.
- With `m00_axis_tready` held at 1, a granted burst streams 1 beat per cycle.
- Between bursts there is 1 idle cycle with all tready=0.
- `grant` is registered and equals the owner throughout GRANT.

## Configuration
- `I2S_ARB_SILENCE_FILL_EN` defined:
  - In IDLE, with neither requester valid, `m00_axis_tvalid`=0, and `m00_axis_tready`=1, load tdata=0, tlast=1, tvalid=1. The transmitter then outputs silence instead of stale data.
  - Fill beats do not change `grant`, `last`, or the beat counter.
  - `underrun_cnt` still counts cycles where tvalid=0 and tready=1, i.e. the fill-load cycle.
- Not defined: in IDLE with no requester valid, `m00_axis_tvalid` stays 0.

## Test plan
- Reset, then `s00` sends 3 beats 0xAA558001, 0xA5A58001, 0x00000001 with tlast on the 3rd, `m00` tready=1:
  - `grant`=01.
  - The 3 words appear on `m00` in order, 1 cycle after accept.
  - `m00_axis_tlast`=1 on the 3rd.
  - Then IDLE for 1 cycle.
- Both requesters continuously valid, 2-beat bursts: grants alternate 01,10,01,10, and `s00` goes first after reset.
- `s01` valid with tlast never asserted, `MAX_BURST`=16:
  - Grant releases after 16 accepts.
  - If `s00` is valid, the next grant is `s00`.
- `m00_axis_tready` toggling 1/0 every cycle during a burst:
  - No beat lost or duplicated.
  - `m00_axis_tdata` stable while stalled.
  - Owner tready=0 while the register is full and stalled.
- `m00_axis_tready`=1, no requesters valid for 10 cycles:
  - Without the macro, `underrun_cnt`=10 and tvalid stays 0.
  - With the macro, a zero word with tlast=1 is emitted and drained.
- Assert `axis_areset` mid-burst while the output is stalled:
  - tvalid, tready and `grant` go to 0 immediately.
  - After release, `s00` is granted first again.
